// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART TX/RX engines: the serializer state
// encoding, default bit timing, frame geometry and a frame-length helper.
// -----------------------------------------------------------------------------
package uart_pkg;

  // 50 MHz / 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned DATA_BITS            = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Clock cycles from the accept edge to the edge where busy falls.
  function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                               input int unsigned parity_en,
                                               input int unsigned stop_bits);
    return (1 + DATA_BITS + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer_if
// Handshake between the Wishbone UART register controller (master) and the
// TX serializer (slave).
//   i_tx_data         byte to send, sampled on the accept cycle
//   i_tx_start        level request, held until the clear pulse
//   o_tx_start_clear  one-cycle acknowledge of acceptance
//   o_tx_busy         frame in flight
// -----------------------------------------------------------------------------
interface uart_tx_serializer_if;

  logic [uart_pkg::DATA_BITS-1:0] i_tx_data;
  logic                           i_tx_start;
  logic                           o_tx_start_clear;
  logic                           o_tx_busy;

  modport master (
    output i_tx_data,
    output i_tx_start,
    input  o_tx_start_clear,
    input  o_tx_busy
  );

  modport slave (
    input  i_tx_data,
    input  i_tx_start,
    output o_tx_start_clear,
    output o_tx_busy
  );

endinterface

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter shared by the TX and RX engines. Counts
// 0..CLKS_PER_BIT-1 and flags the terminal count; clear_i holds it at zero.
//   clk      system clock
//   rst      synchronous active-high reset
//   clear_i  synchronous clear (restarts the bit period)
//   tick_o   high during the last cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned   CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == TERMINAL);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Serial transmit engine: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. All outputs are registered.
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   controller handshake (data, start, start_clear, busy)
//   o_tx  serial TX line, idle high
// -----------------------------------------------------------------------------
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_serializer_if.slave  bus,
  output logic                 o_tx
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic             ODD       = 1'(PARITY_ODD);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 parity_q, parity_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 clear_q, clear_d;
  logic                 baud_clear;
  logic                 baud_tick;

  // Held in clear while idle so the start bit gets a full period from the
  // accept edge.
  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .clear_i (baud_clear),
    .tick_o  (baud_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    parity_d   = parity_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    clear_d    = 1'b0;
    baud_clear = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_clear = 1'b1;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        if (bus.i_tx_start) begin
          shift_d    = bus.i_tx_data;
          parity_d   = (^bus.i_tx_data) ^ ODD;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          clear_d    = 1'b1;
          state_d    = START;
        end
      end

      START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            // tx is registered, so the bit going out next is shift_q[1],
            // which becomes shift[0] on this same edge.
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

      PARITY: begin
        if (baud_tick) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end

      STOP: begin
        if (baud_tick) begin
          if (stop_idx_q == LAST_STOP) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      parity_q   <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      parity_q   <= parity_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      clear_q    <= clear_d;
    end
  end

  assign bus.o_tx_start_clear = clear_q;
  assign bus.o_tx_busy        = busy_q;
  assign o_tx                 = tx_q;

endmodule
